gearbox_destruct: RTL

- Streaming wide-to-narrow width converter for the VDMA read path: unpacks ISIZE-bit memory beats into OSIZE-bit pixels.
- Handles any ISIZE/OSIZE ratio, including non-integer ratios, through a residual-bit accumulator.
- Uses valid/ready handshakes on both sides and a per-line pixel counter that asserts olast on the last pixel of each line.
- Discards the unused residual bits of the final beat of each line, so every line starts on a beat boundary.

---
 rtl/gearbox_destruct_pkg.sv | 34 +++
 rtl/gearbox_destruct_if.sv | 25 ++
 rtl/gearbox_line_counter.sv | 39 +++
 rtl/gearbox_destruct.sv | 87 ++++++++
 4 files changed

// File: rtl/gearbox_destruct_pkg.sv
// Shared sizing, helpers and bit-order type for the VDMA read-path gearbox.
// GEARBOX_MSB_FIRST_EN selects MSB-first pixel order within each beat.
package vdma_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int GB_ISIZE = 256;
   localparam int GB_OSIZE = 24;
   localparam int GB_PIX_W = 16;
   localparam int BUF_W    = GB_ISIZE + GB_OSIZE;
   localparam int CNT_W    = clog2(BUF_W + 1);

   typedef enum logic {
      ORDER_LSB_FIRST = 1'b0,
      ORDER_MSB_FIRST = 1'b1
   } bit_order_e;

`ifdef GEARBOX_MSB_FIRST_EN
   localparam bit_order_e BIT_ORDER = ORDER_MSB_FIRST;
`else
   localparam bit_order_e BIT_ORDER = ORDER_LSB_FIRST;
`endif

endpackage

// File: rtl/gearbox_destruct_if.sv
// Beat-in / pixel-out stream bundle for the gearbox.
// Both sides: a transfer happens on a rising edge where valid && ready; data
// (and olast) must be held while valid is high and ready is low.
interface gearbox_destruct_if import vdma_pkg::*; #(
   parameter int ISIZE = GB_ISIZE,
   parameter int OSIZE = GB_OSIZE
);
   logic             ivalid;
   logic             iready;
   logic [ISIZE-1:0] idata;
   logic             ovalid;
   logic             oready;
   logic [OSIZE-1:0] odata;
   logic             olast;

   modport master (
      output ivalid, idata, oready,
      input  iready, ovalid, odata, olast
   );

   modport slave (
      input  ivalid, idata, oready,
      output iready, ovalid, odata, olast
   );
endinterface

// File: rtl/gearbox_line_counter.sv
// Per-line pixel counter: flags the last pixel of a line, saturates when the
// line length is unlimited.
module gearbox_line_counter #(
   parameter int PIX_W = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             ialign,
   input  logic [PIX_W-1:0] line_pixels,
   input  logic             ovalid,
   input  logic             ofire,
   output logic             olast
);
   logic [PIX_W-1:0] pix_q, pix_d;

   assign olast = ovalid && (line_pixels != '0) &&
                  (pix_q == line_pixels - PIX_W'(1));

   always_comb begin
      pix_d = pix_q;
      if (ialign) begin
         pix_d = '0;
      end else if (ofire) begin
         if (olast) begin
            pix_d = '0;
         end else if (pix_q != '1) begin
            pix_d = pix_q + PIX_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         pix_q <= '0;
      end else begin
         pix_q <= pix_d;
      end
   end
endmodule

// File: rtl/gearbox_destruct.sv
// Wide-to-narrow stream gearbox: unpacks ISIZE-bit beats into OSIZE-bit pixels
// via a residual-bit accumulator. GEARBOX_MSB_FIRST_EN reverses in-beat order.
module gearbox_destruct import vdma_pkg::*; #(
   parameter int ISIZE = GB_ISIZE,
   parameter int OSIZE = GB_OSIZE,
   parameter int PIX_W = GB_PIX_W
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             ialign,
   input  logic [PIX_W-1:0] line_pixels,
   gearbox_destruct_if.slave bus
);
   localparam int BW = ISIZE + OSIZE;
   localparam int CW = clog2(BW + 1);
   localparam logic [CW-1:0] OS_C  = CW'(OSIZE);
   localparam logic [CW-1:0] OS2_C = CW'(2 * OSIZE);
   localparam logic [CW-1:0] IS_C  = CW'(ISIZE);

   logic [BW-1:0] buf_q, buf_d, buf_s;
   logic [BW-1:0] beat_ext, beat_mask;
   logic [CW-1:0] cnt_q, cnt_d, cnt_s;
   logic          ovalid, ofire, ifire, olast;

   assign ovalid     = (cnt_q >= OS_C);
   assign ofire      = ovalid && bus.oready;
   // oready feeds iready combinationally so a beat can land while a pixel leaves.
   assign bus.iready = (cnt_q < OS_C) || (bus.oready && (cnt_q < OS2_C));
   assign ifire      = bus.ivalid && bus.iready;
   assign bus.ovalid = ovalid;
   assign bus.olast  = olast;
   assign beat_ext   = BW'(bus.idata);
   assign beat_mask  = BW'({ISIZE{1'b1}});

`ifdef GEARBOX_MSB_FIRST_EN
   assign bus.odata = buf_q[BW-1 -: OSIZE];
`else
   assign bus.odata = buf_q[OSIZE-1:0];
`endif

   gearbox_line_counter #(.PIX_W(PIX_W)) u_line_counter (
      .clock       (clock),
      .rst         (rst),
      .ialign      (ialign),
      .line_pixels (line_pixels),
      .ovalid      (ovalid),
      .ofire       (ofire),
      .olast       (olast)
   );

   always_comb begin
      buf_s = buf_q;
      cnt_s = cnt_q;
      if (ofire) begin
`ifdef GEARBOX_MSB_FIRST_EN
         buf_s = buf_q << OSIZE;
`else
         buf_s = buf_q >> OSIZE;
`endif
         // The residual of a line's final beat is dropped so the next line is beat-aligned.
         cnt_s = olast ? '0 : (cnt_q - OS_C);
      end

      buf_d = buf_s;
      cnt_d = cnt_s;
      if (ialign) begin
         cnt_d = '0;
      end else if (ifire) begin
`ifdef GEARBOX_MSB_FIRST_EN
         buf_d = (buf_s & ~(beat_mask << (OS_C - cnt_s))) | (beat_ext << (OS_C - cnt_s));
`else
         buf_d = (buf_s & ~(beat_mask << cnt_s)) | (beat_ext << cnt_s);
`endif
         cnt_d = cnt_s + IS_C;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end
endmodule
